// File: rtl/rns_pkg.sv
// -----------------------------------------------------------------------------
// rns_pkg
// Shared definitions for the RNS converters built on the moduli set
// {2^N-1, 2^N, 2^N+1, 2^(N+1)-1}.
//
// Contents:
//   RNS_N           default base exponent used by the converter family
//   rns_state_e     converter control states
//   rns_residues_t  residue tuple (r1..r4) at the default N, in the same
//                   order and widths the reverse converters consume
//   rns_ceil_div    integer ceiling division used for digit counts
//   rns_range_m     dynamic range M of the moduli set for a given N
// -----------------------------------------------------------------------------
package rns_pkg;

    localparam int RNS_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FOLD  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } rns_state_e;

    typedef struct packed {
        logic [RNS_N-1:0] r1;
        logic [RNS_N-1:0] r2;
        logic [RNS_N:0]   r3;
        logic [RNS_N:0]   r4;
    } rns_residues_t;

    function automatic int rns_ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Product of the four moduli. 128 bits covers N up to 16 with margin.
    function automatic logic [127:0] rns_range_m(input int n);
        logic [127:0] p2;
        logic [127:0] m1;
        logic [127:0] m3;
        logic [127:0] m4;
        p2 = 128'd1 << n;
        m1 = p2 - 128'd1;
        m3 = p2 + 128'd1;
        m4 = (p2 << 1) - 128'd1;
        return m1 * p2 * m3 * m4;
    endfunction

endpackage

// File: rtl/rns_eac_add.sv
// -----------------------------------------------------------------------------
// rns_eac_add
// Combinational end-around-carry adder modulo 2^W-1.
//
// Ports:
//   a, b  in  W  operands, each in 0..2^W-1 (all-ones is a second zero)
//   sum   out W  (a + b) mod 2^W-1, in 0..2^W-1 (all-ones may appear)
//
// Folding the carry back in cannot carry again: with a carry out the low
// part is at most 2^W-2, so adding one stays within W bits.
// -----------------------------------------------------------------------------
module rns_eac_add
    import rns_pkg::*;
#(
    parameter int W = RNS_N
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        sum = raw[W-1:0] + {{(W-1){1'b0}}, raw[W]};
    end

endmodule

// File: rtl/rns_fwd_conv.sv
// -----------------------------------------------------------------------------
// rns_fwd_conv
// Iterative binary-to-residue converter for the moduli set
// {2^N-1, 2^N, 2^N+1, 2^(N+1)-1}. The (4N+1)-bit operand is folded one
// digit per cycle: N-bit digits feed the 2^N-1 and 2^N+1 channels (weights
// 1 and alternating +/-1), (N+1)-bit digits feed the 2^(N+1)-1 channel
// (weight 1), and digit 0 is the residue mod 2^N.
//
// Ports:
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous active-high reset
//   in_valid   in   1     operand valid
//   in_ready   out  1     converter idle and able to accept
//   in_x       in   4N+1  operand X
//   out_valid  out  1     residues valid
//   out_ready  in   1     consumer takes the residues
//   r1         out  N     X mod 2^N-1
//   r2         out  N     X mod 2^N
//   r3         out  N+1   X mod 2^N+1
//   r4         out  N+1   X mod 2^(N+1)-1
//   out_err    out  1     X >= M (only with RNS_FWD_RANGE_CHECK_EN)
//
// Build option: define RNS_FWD_RANGE_CHECK_EN to build the range comparator;
// otherwise out_err is tied low.
// -----------------------------------------------------------------------------
module rns_fwd_conv
    import rns_pkg::*;
#(
    parameter int N = RNS_N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*N:0]    in_x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    r1,
    output logic [N-1:0]    r2,
    output logic [N:0]      r3,
    output logic [N:0]      r4,
    output logic            out_err
);

    localparam int XW = 4*N + 1;
    localparam int K  = rns_ceil_div(XW, N);
    localparam int K4 = rns_ceil_div(XW, N + 1);
    localparam int CW = $clog2(K);

    localparam logic [N-1:0]   MOD1 = {N{1'b1}};
    localparam logic [N:0]     MOD4 = {(N+1){1'b1}};
    localparam logic [N+1:0]   MOD3 = {2'b01, {(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_LAST = CW'(K - 1);
    localparam logic [CW-1:0]  CNT_E_END = CW'(K4);

    rns_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [XW-1:0]  sh_q, sh_d;
    logic [XW-1:0]  sh4_q, sh4_d;
    logic [N-1:0]   acc1_q, acc1_d;
    logic [N-1:0]   acc2_q, acc2_d;
    logic [N:0]     acc3_q, acc3_d;
    logic [N:0]     acc4_q, acc4_d;
    logic [N-1:0]   r1_q, r1_d;
    logic [N-1:0]   r2_q, r2_d;
    logic [N:0]     r3_q, r3_d;
    logic [N:0]     r4_q, r4_d;
    logic           out_valid_q, out_valid_d;

    logic [N-1:0]   cur_d;
    logic [N:0]     cur_e;
    logic [N-1:0]   acc1_sum;
    logic [N:0]     acc4_sum;
    logic [N+1:0]   sum3;
    logic [N:0]     acc3_next;
    logic           sum3_top_unused;

    // Current digits come from the low end of two shift registers, one
    // stepping by N bits and one by N+1 bits. The wide digit is forced to
    // zero past its last position even though the zero fill already does so.
    always_comb begin
        cur_d = sh_q[N-1:0];
        cur_e = (cnt_q < CNT_E_END) ? sh4_q[N:0] : '0;
    end

    rns_eac_add #(.W(N)) u_add1 (
        .a   (acc1_q),
        .b   (cur_d),
        .sum (acc1_sum)
    );

    rns_eac_add #(.W(N + 1)) u_add4 (
        .a   (acc4_q),
        .b   (cur_e),
        .sum (acc4_sum)
    );

    // Mod 2^N+1 step: 2^N is -1, so even digits add and odd digits subtract.
    // The accumulator stays in 0..2^N with a single correction by 2^N+1.
    always_comb begin
        if (!cnt_q[0]) begin
            sum3 = {1'b0, acc3_q} + {2'b00, cur_d};
            if (sum3 >= MOD3) begin
                sum3 = sum3 - MOD3;
            end
        end else begin
            if ({1'b0, acc3_q} >= {2'b00, cur_d}) begin
                sum3 = {1'b0, acc3_q} - {2'b00, cur_d};
            end else begin
                sum3 = {1'b0, acc3_q} + MOD3 - {2'b00, cur_d};
            end
        end
        acc3_next       = sum3[N:0];
        sum3_top_unused = sum3[N+1];
    end

    // Next-state and datapath decode for the IDLE/FOLD/FINAL/DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        sh4_d       = sh4_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        acc3_d      = acc3_q;
        acc4_d      = acc4_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        r4_d        = r4_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_d    = in_x;
                    sh4_d   = in_x;
                    acc1_d  = '0;
                    acc2_d  = '0;
                    acc3_d  = '0;
                    acc4_d  = '0;
                    cnt_d   = '0;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                acc1_d = acc1_sum;
                acc3_d = acc3_next;
                acc4_d = acc4_sum;
                if (cnt_q == '0) begin
                    acc2_d = cur_d;
                end
                sh_d  = sh_q >> N;
                sh4_d = sh4_q >> (N + 1);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                // All-ones is the redundant zero of a 2^W-1 channel.
                r1_d        = (acc1_q == MOD1) ? '0 : acc1_q;
                r2_d        = acc2_q;
                r3_d        = acc3_q;
                r4_d        = (acc4_q == MOD4) ? '0 : acc4_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            sh4_q       <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            acc3_q      <= '0;
            acc4_q      <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            r4_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            sh4_q       <= sh4_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            acc3_q      <= acc3_d;
            acc4_q      <= acc4_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            r4_q        <= r4_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign r1        = r1_q;
    assign r2        = r2_q;
    assign r3        = r3_q;
    assign r4        = r4_q;

`ifdef RNS_FWD_RANGE_CHECK_EN
    localparam logic [127:0] RANGE_M = rns_range_m(N);

    logic err_q, err_d;
    logic out_err_q, out_err_d;

    // The range flag is captured with the operand and released with the
    // residues so it always describes the item being presented.
    always_comb begin
        err_d     = err_q;
        out_err_d = out_err_q;
        if ((state_q == IDLE) && in_valid) begin
            err_d = (128'(in_x) >= RANGE_M);
        end
        if (state_q == FINAL) begin
            out_err_d = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            err_q     <= err_d;
            out_err_q <= out_err_d;
        end
    end

    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule
